kbd_host_ctrl: RTL and testbench
================================

Name: kbd_host_ctrl

Overview:
- Second-generation PS/2 keyboard host controller. Sits between the byte-level PS/2 receive/transmit engines and the CPU peripheral bus.
- Buffers received scan codes in a parametrised FIFO and tracks Caps/Num/Scroll lock state from make codes.
- Drives the full LED update handshake with the keyboard: 0xED, then the LED byte, each with ACK wait, resend handling and timeout.

Parameters:
- FIFO_DEPTH, 16, scan-code FIFO entries; power of 2, 2..256.
- ACK_TIMEOUT, 500000, cycles to wait for keyboard ACK after a byte is sent (10 ms at 50 MHz).
- MAX_RETRY, 3, resends allowed per command byte on 0xFE before giving up.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx_data  in  8  byte from the PS/2 receive engine.
- rx_rdy  in  1  one-cycle pulse; rx_data valid.
- tx_sent  in  1  one-cycle pulse; transmit engine has finished the byte.
- rx_en  out  1  enables the receive engine.
- tx_en  out  1  enables the transmit engine.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- rd_ack  in  1  host pops the FIFO head.
- clr_err  in  1  clears the overflow and cmd_err sticky flags.
- data_out  out  8  FIFO head (first-word fall-through).
- rda_out  out  1  FIFO non-empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky; a byte was dropped on a full FIFO.
- cmd_err  out  1  sticky; LED command abandoned (retries exhausted or timeout).
- leds  out  3  {caps, num, scroll} lock state.
- busy  out  1  LED command sequence in progress.

Behaviour:
- Reset values: state RECEIVE, rx_en=1, tx_en=0, tx_data=0xFF, tx_start=0, data_out=0x00, rda_out=0, fifo_count=0, overflow=0, cmd_err=0, leds=0, busy=0. All internal flags, counters and the FIFO are cleared.
- Reset mid-sequence: abandons the command immediately, with no further tx_start.

FIFO:
- Push on rx_rdy except for bytes consumed as ACK/resend (see FSM).
- Register timing: rx_rdy in cycle N gives rda_out=1 and a valid data_out in cycle N+1.
- data_out=0x00 whenever the FIFO is empty.
- Pop on rd_ack when non-empty. rd_ack when empty is ignored.
- Push when full without a simultaneous pop: the byte is dropped and overflow is set.
- Push and pop together when full: both occur, count is unchanged, no overflow.
- Pointers wrap modulo FIFO_DEPTH.
- clr_err clears overflow and cmd_err. If a new overflow or error occurs in the same cycle as clr_err, the flag is set.

Lock detection (all received bytes, any state, including ones consumed as ACK are excluded):
- 0x58 toggles caps, 0x77 toggles num, 0x7E toggles scroll.
- A toggle happens only when the previous byte was not 0xF0 or 0xE0, and when no E1 suppression is active.
- Byte 0xE1 suppresses lock detection for the next 7 received bytes (Pause sequence).
- leds updates in cycle N+1. led_req is set in the same cycle.
- led_req stays set while a sequence is running; a new sequence starts after the current one ends.

FSM states and transitions:
- RECEIVE: rx_en=1, busy=0.
  - If led_req=1: clear led_req, snapshot leds into the LED byte {5'b0, scroll_bit0, num_bit1, caps_bit2} (bit0=scroll, bit1=num, bit2=caps), retry=0, go to SEND_CMD.
- SEND_CMD: tx_en=1, rx_en=0, tx_data=0xED.
  - tx_start pulses only in the first cycle of the state.
  - tx_sent goes to WAIT_ACK1 with the timeout counter reset.
- WAIT_ACK1: rx_en=1.
  - Receive 0xFA: consumed (not pushed), go to SEND_VAL with retry=0.
  - Receive 0xFE: consumed. If retry<MAX_RETRY, retry++ and return to SEND_CMD. Otherwise set cmd_err and go to RECEIVE.
  - Any other byte: pushed to the FIFO as a scan code and subject to lock detection.
  - Counter reaches ACK_TIMEOUT: set cmd_err, go to RECEIVE.
- SEND_VAL: same as SEND_CMD but tx_data is the LED byte; tx_sent goes to WAIT_ACK2.
- WAIT_ACK2: same as WAIT_ACK1. 0xFA goes to RECEIVE; 0xFE resends from SEND_VAL.
- busy=1 in every state except RECEIVE.
- rx_rdy during SEND_* states is still pushed to the FIFO.

Test Plan:
- Rx 0x1C, 0xF0, 0x1C; no rd_ack -> fifo_count=3, data_out=0x1C, rda_out=1 one cycle after the first rx_rdy; leds unchanged.
- Rx 0x58 -> leds=3'b100, busy=1, tx_start with 0xED. Model ACK 0xFA -> tx_start with 0x04. ACK 0xFA -> RECEIVE; FIFO holds 0x58 only (ACKs not pushed).
- Rx 0x58, keyboard answers 0xFE four times to 0xED -> 4 transmissions of 0xED, then cmd_err=1, RECEIVE, busy=0.
- LED sequence, no ACK after 0xED -> after ACK_TIMEOUT cycles cmd_err=1, RECEIVE. clr_err -> cmd_err=0.
- Rx E1 14 77 E1 F0 14 F0 77 -> leds stay 000, all 8 bytes in the FIFO. Then rx 0x77 -> leds=010.
- FIFO_DEPTH=4: push 5 bytes -> count=4, overflow=1, 5th byte dropped. Then push and rd_ack in the same cycle when full -> count=4, no new drop. Pop all -> data_out=0x00, rda_out=0.

Source files
------------

// File: rtl/kbd_host_ctrl.sv
// -----------------------------------------------------------------------------
// kbd_host_ctrl
//
// PS/2 keyboard host controller. It sits between the byte-level PS/2
// receive/transmit engines and the CPU peripheral bus. The block:
//   - buffers received scan codes in a first-word-fall-through FIFO,
//   - tracks Caps/Num/Scroll lock state from make codes,
//   - runs the LED update handshake with the keyboard: 0xED, then the LED
//     byte. Each byte waits for an ACK (0xFA), is resent on 0xFE up to
//     MAX_RETRY times, and is abandoned on timeout.
//
// Parameters:
//   FIFO_DEPTH   scan-code FIFO entries (power of 2, 2..256)
//   ACK_TIMEOUT  cycles to wait for a keyboard ACK after a byte is sent
//   MAX_RETRY    resends allowed per command byte before giving up
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   rx_data      byte from the PS/2 receive engine
//   rx_rdy       one-cycle pulse, rx_data valid
//   tx_sent      one-cycle pulse, transmit engine finished the byte
//   rx_en        receive engine enable
//   tx_en        transmit engine enable
//   tx_data      byte to transmit
//   tx_start     one-cycle pulse requesting transmission of tx_data
//   rd_ack       host pops the FIFO head
//   clr_err      clears the overflow and cmd_err sticky flags
//   data_out     FIFO head (0x00 when empty)
//   rda_out      FIFO non-empty
//   fifo_count   FIFO occupancy
//   overflow     sticky, a byte was dropped on a full FIFO
//   cmd_err      sticky, an LED command was abandoned
//   leds         {caps, num, scroll} lock state
//   busy         LED command sequence in progress
// -----------------------------------------------------------------------------
module kbd_host_ctrl #(
    parameter int FIFO_DEPTH  = 16,
    parameter int ACK_TIMEOUT = 500000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_rdy,
    input  logic                          tx_sent,
    output logic                          rx_en,
    output logic                          tx_en,
    output logic [7:0]                    tx_data,
    output logic                          tx_start,
    input  logic                          rd_ack,
    input  logic                          clr_err,
    output logic [7:0]                    data_out,
    output logic                          rda_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          cmd_err,
    output logic [2:0]                    leds,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [2:0] ST_RECEIVE   = 3'd0;
    localparam logic [2:0] ST_SEND_CMD  = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK1 = 3'd2;
    localparam logic [2:0] ST_SEND_VAL  = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK2 = 3'd4;

    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;
    localparam logic [7:0] BYTE_SETLED = 8'hED;
    localparam logic [7:0] BYTE_BREAK  = 8'hF0;
    localparam logic [7:0] BYTE_EXT0   = 8'hE0;
    localparam logic [7:0] BYTE_EXT1   = 8'hE1;
    localparam logic [7:0] KEY_CAPS    = 8'h58;
    localparam logic [7:0] KEY_NUM     = 8'h77;
    localparam logic [7:0] KEY_SCROLL  = 8'h7E;

    logic [2:0]    state;
    logic          tx_first;
    logic [RW-1:0] retry;
    logic [TW-1:0] tcnt;
    logic [7:0]    led_byte;
    logic          led_req;
    logic [7:0]    prev_byte;
    logic [2:0]    e1_left;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic in_wait;
    logic is_ack;
    logic is_resend;
    logic scan_valid;
    logic fifo_full;
    logic fifo_empty;
    logic do_pop;
    logic do_push;
    logic drop;
    logic suppress;
    logic after_prefix;
    logic tgl_caps;
    logic tgl_num;
    logic tgl_scroll;
    logic any_toggle;
    logic start_seq;
    logic timeout;
    logic exhaust;
    logic fsm_err;

    // ACK/resend bytes are swallowed only while waiting for an answer;
    // everything else the keyboard sends is treated as a scan code.
    always_comb begin
        in_wait    = (state == ST_WAIT_ACK1) || (state == ST_WAIT_ACK2);
        is_ack     = rx_rdy && in_wait && (rx_data == BYTE_ACK);
        is_resend  = rx_rdy && in_wait && (rx_data == BYTE_RESEND);
        scan_valid = rx_rdy && !is_ack && !is_resend;

        fifo_full  = (count == CW'(FIFO_DEPTH));
        fifo_empty = (count == '0);
        do_pop     = rd_ack && !fifo_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push    = scan_valid && (!fifo_full || do_pop);
        drop       = scan_valid && fifo_full && !do_pop;
    end

    // Lock keys toggle only as plain make codes: not after a break/extended
    // prefix, and not inside the 7-byte tail of a Pause (0xE1) sequence.
    always_comb begin
        suppress     = (e1_left != 3'd0);
        after_prefix = (prev_byte == BYTE_BREAK) || (prev_byte == BYTE_EXT0);
        tgl_caps     = scan_valid && !suppress && !after_prefix && (rx_data == KEY_CAPS);
        tgl_num      = scan_valid && !suppress && !after_prefix && (rx_data == KEY_NUM);
        tgl_scroll   = scan_valid && !suppress && !after_prefix && (rx_data == KEY_SCROLL);
        any_toggle   = tgl_caps || tgl_num || tgl_scroll;
    end

    // Abandon conditions for the LED command. An arriving ACK/resend takes
    // priority over a timeout landing in the same cycle.
    always_comb begin
        start_seq = (state == ST_RECEIVE) && led_req;
        timeout   = in_wait && !is_ack && !is_resend && (tcnt == TW'(ACK_TIMEOUT - 1));
        exhaust   = is_resend && (retry >= RW'(MAX_RETRY));
        fsm_err   = timeout || exhaust;
    end

    // Engine enables and status are pure decodes of the state. tx_first is
    // only ever high in the first cycle of a SEND state, so it is the
    // tx_start pulse directly.
    always_comb begin
        tx_en    = (state == ST_SEND_CMD) || (state == ST_SEND_VAL);
        rx_en    = !tx_en;
        busy     = (state != ST_RECEIVE);
        tx_start = tx_first;
    end

    // LED command sequencer. tx_data is loaded on entry to each SEND state
    // so the byte is stable while tx_start is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RECEIVE;
            tx_first <= 1'b0;
            retry    <= '0;
            tcnt     <= '0;
            led_byte <= 8'h00;
            tx_data  <= 8'hFF;
        end else begin
            tx_first <= 1'b0;
            case (state)
                ST_RECEIVE: begin
                    if (led_req) begin
                        led_byte <= {5'b00000, leds};
                        retry    <= '0;
                        tx_data  <= BYTE_SETLED;
                        tx_first <= 1'b1;
                        state    <= ST_SEND_CMD;
                    end
                end
                ST_SEND_CMD: begin
                    if (tx_sent) begin
                        tcnt  <= '0;
                        state <= ST_WAIT_ACK1;
                    end
                end
                ST_WAIT_ACK1: begin
                    if (is_ack) begin
                        retry    <= '0;
                        tx_data  <= led_byte;
                        tx_first <= 1'b1;
                        state    <= ST_SEND_VAL;
                    end else if (is_resend) begin
                        if (exhaust) begin
                            state <= ST_RECEIVE;
                        end else begin
                            retry    <= retry + RW'(1);
                            tx_data  <= BYTE_SETLED;
                            tx_first <= 1'b1;
                            state    <= ST_SEND_CMD;
                        end
                    end else if (timeout) begin
                        state <= ST_RECEIVE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_SEND_VAL: begin
                    if (tx_sent) begin
                        tcnt  <= '0;
                        state <= ST_WAIT_ACK2;
                    end
                end
                ST_WAIT_ACK2: begin
                    if (is_ack) begin
                        state <= ST_RECEIVE;
                    end else if (is_resend) begin
                        if (exhaust) begin
                            state <= ST_RECEIVE;
                        end else begin
                            retry    <= retry + RW'(1);
                            tx_data  <= led_byte;
                            tx_first <= 1'b1;
                            state    <= ST_SEND_VAL;
                        end
                    end else if (timeout) begin
                        state <= ST_RECEIVE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    state <= ST_RECEIVE;
                end
            endcase
        end
    end

    // Lock state and the LED request. A toggle during a running sequence
    // keeps led_req set so a fresh sequence follows once back in RECEIVE;
    // a toggle in the same cycle as a sequence start wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            leds      <= 3'b000;
            led_req   <= 1'b0;
            prev_byte <= 8'h00;
            e1_left   <= 3'd0;
        end else begin
            leds    <= leds ^ {tgl_caps, tgl_num, tgl_scroll};
            led_req <= any_toggle || (led_req && !start_seq);
            if (scan_valid) begin
                prev_byte <= rx_data;
                // An E1 inside the suppression window only counts down; it
                // does not restart the window.
                if (e1_left != 3'd0) begin
                    e1_left <= e1_left - 3'd1;
                end else if (rx_data == BYTE_EXT1) begin
                    e1_left <= 3'd7;
                end
            end
        end
    end

    // Scan-code FIFO storage and pointers; pointers wrap naturally because
    // the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= rx_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new event in the clearing cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            overflow <= drop || (overflow && !clr_err);
            cmd_err  <= fsm_err || (cmd_err && !clr_err);
        end
    end

    always_comb begin
        data_out   = fifo_empty ? 8'h00 : mem[rd_ptr];
        rda_out    = !fifo_empty;
        fifo_count = count;
    end

endmodule

// File: tb/tb_kbd_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kbd_host_ctrl
//
// Self-checking bench for kbd_host_ctrl. The bench plays the keyboard: it
// answers the LED command bytes with ACK, resend or silence, and feeds scan
// codes. A transaction-level model (byte queue, lock bits, sticky flags)
// predicts the host-visible outputs after every stimulus cycle.
// -----------------------------------------------------------------------------
module tb_kbd_host_ctrl;

    localparam int DEPTH   = 8;
    localparam int TMO     = 40;
    localparam int RETRIES = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [7:0]                rx_data;
    logic                      rx_rdy;
    logic                      tx_sent;
    logic                      rx_en;
    logic                      tx_en;
    logic [7:0]                tx_data;
    logic                      tx_start;
    logic                      rd_ack;
    logic                      clr_err;
    logic [7:0]                data_out;
    logic                      rda_out;
    logic [$clog2(DEPTH):0]    fifo_count;
    logic                      overflow;
    logic                      cmd_err;
    logic [2:0]                leds;
    logic                      busy;

    kbd_host_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .ACK_TIMEOUT (TMO),
        .MAX_RETRY   (RETRIES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .tx_sent    (tx_sent),
        .rx_en      (rx_en),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .rd_ack     (rd_ack),
        .clr_err    (clr_err),
        .data_out   (data_out),
        .rda_out    (rda_out),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .cmd_err    (cmd_err),
        .leds       (leds),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [2:0] mLeds;
    bit         mOvf;
    bit         mErr;
    bit         mPending;
    logic [7:0] mPrev;
    int         mE1Left;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        mq.delete();
        mLeds    = 3'b000;
        mOvf     = 0;
        mErr     = 0;
        mPending = 0;
        mPrev    = 8'h00;
        mE1Left  = 0;
    endtask

    // Lock rules: plain make codes toggle unless preceded by F0/E0 or
    // within the seven bytes following a Pause (E1) prefix.
    task automatic modelLock(input logic [7:0] b);
        if (mE1Left > 0) begin
            mE1Left--;
        end else if (b == 8'hE1) begin
            mE1Left = 7;
        end else if (mPrev != 8'hF0 && mPrev != 8'hE0) begin
            if (b == 8'h58) begin mLeds[2] = ~mLeds[2]; mPending = 1; end
            if (b == 8'h77) begin mLeds[1] = ~mLeds[1]; mPending = 1; end
            if (b == 8'h7E) begin mLeds[0] = ~mLeds[0]; mPending = 1; end
        end
        mPrev = b;
    endtask

    // One stimulus cycle with a scan byte (never an ACK/resend answer),
    // optional pop and optional error clear; the model follows.
    task automatic applyStimulus(input bit rxv, input logic [7:0] b, input bit pop, input bit clr);
        bit setOvf;
        rx_rdy  = rxv;
        rx_data = b;
        rd_ack  = pop;
        clr_err = clr;
        tick();
        rx_rdy  = 0;
        rd_ack  = 0;
        clr_err = 0;
        setOvf  = 0;
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (rxv) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else setOvf = 1;
            modelLock(b);
        end
        mOvf = setOvf || (mOvf && !clr);
        mErr = mErr && !clr;
    endtask

    task automatic checkState();
        checkOutput("fifoCount", fifo_count, mq.size());
        checkOutput("dataOut", data_out, (mq.size() > 0) ? mq[0] : 8'h00);
        checkOutput("rdaOut", rda_out, mq.size() > 0);
        checkOutput("leds", leds, mLeds);
        checkOutput("overflow", overflow, mOvf);
        checkOutput("cmdErr", cmd_err, mErr);
    endtask

    task automatic checkResetValues();
        checkOutput("rstRxEn", rx_en, 1);
        checkOutput("rstTxEn", tx_en, 0);
        checkOutput("rstTxData", tx_data, 8'hFF);
        checkOutput("rstTxStart", tx_start, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDataOut", data_out, 8'h00);
        checkOutput("rstRda", rda_out, 0);
        checkOutput("rstCount", fifo_count, 0);
        checkOutput("rstOvf", overflow, 0);
        checkOutput("rstErr", cmd_err, 0);
        checkOutput("rstLeds", leds, 3'b000);
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1, b, 0, 0);
        checkState();
    endtask

    // Keyboard answer while the host waits; swallowed by the controller.
    task automatic respond(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1;
        tick();
        rx_rdy  = 0;
    endtask

    // Wait for a transmit request, check it, then complete it.
    task automatic awaitTx(input logic [7:0] expByte, output bit got);
        int n;
        n = 0;
        while (tx_start !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checkOutput("txStartSeen", tx_start, 1);
        got = (tx_start === 1'b1);
        if (got) begin
            checkOutput("txData", tx_data, expByte);
            checkOutput("txEnSend", tx_en, 1);
            checkOutput("rxEnSend", rx_en, 0);
            checkOutput("busySend", busy, 1);
            tick();
            checkOutput("txStartPulse", tx_start, 0);
            tx_sent = 1;
            tick();
            tx_sent = 0;
            checkOutput("rxEnWait", rx_en, 1);
            checkOutput("txEnWait", tx_en, 0);
        end
    endtask

    task automatic waitTimeout();
        int n;
        n = 0;
        while (busy === 1'b1 && n < TMO + 20) begin
            tick();
            n++;
        end
        checkOutput("timeoutEnd", busy, 0);
        checkOutput("timeoutWindow", (n >= TMO - 2 && n <= TMO + 2), 1);
        mErr = 1;
    endtask

    // One command byte: transmitted, answered with nFe resends then ACK,
    // or left unanswered. Gives up after RETRIES resends.
    task automatic phase(input logic [7:0] expByte, input int nFe, input bit noAck,
                         input bit interleave, output bit ok);
        bit got;
        logic [7:0] ib;
        ok = 0;
        for (int a = 0; a <= RETRIES; a++) begin
            awaitTx(expByte, got);
            if (!got) return;
            if (interleave && a == 0) begin
                do ib = 8'($urandom_range(0, 255)); while (ib == 8'hFA || ib == 8'hFE);
                sendByte(ib);
            end
            if (noAck) begin
                waitTimeout();
                return;
            end
            if (a < nFe) begin
                respond(8'hFE);
                if (a == RETRIES) begin
                    mErr = 1;
                    return;
                end
            end else begin
                respond(8'hFA);
                ok = 1;
                return;
            end
        end
    endtask

    task automatic runLedSeq(input int fe1, input int fe2, input int toMode, input bit inter);
        logic [7:0] ledByte;
        bit ok;
        mPending = 0;
        ledByte  = {5'b00000, mLeds};
        phase(8'hED, fe1, toMode == 1, inter, ok);
        if (ok) phase(ledByte, fe2, toMode == 2, 0, ok);
        checkOutput("busyEnd", busy, 0);
        checkState();
        if (!ok && !mPending) begin
            repeat (3) begin
                tick();
                checkOutput("noTxAfterAbort", tx_start, 0);
            end
        end
    endtask

    task automatic serviceLeds(input int fe1, input int fe2, input int toMode, input bit inter);
        int guard;
        runLedSeq(fe1, fe2, toMode, inter);
        guard = 0;
        while (mPending && guard < 10) begin
            runLedSeq(0, 0, 0, 0);
            guard++;
        end
    endtask

    task automatic drainFifo();
        int guard;
        guard = 0;
        while (mq.size() > 0 && guard < 2 * DEPTH) begin
            applyStimulus(0, 8'h00, 1, 0);
            guard++;
        end
        checkState();
    endtask

    function automatic logic [7:0] randPool();
        case ($urandom_range(0, 9))
            0:       return 8'h58;
            1:       return 8'h77;
            2:       return 8'h7E;
            3:       return 8'hF0;
            4:       return 8'hE0;
            5:       return 8'hE1;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] pauseSeq [8];
        bit got;
        int act;
        pauseSeq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        rst = 1; rx_data = 0; rx_rdy = 0; tx_sent = 0; rd_ack = 0; clr_err = 0;
        modelReset();
        repeat (3) tick();
        rst = 0;
        tick();
        checkResetValues();

        // Plain scan codes, registered one cycle after rx_rdy
        sendByte(8'h1C);
        checkOutput("firstHead", data_out, 8'h1C);
        sendByte(8'hF0);
        sendByte(8'h1C);
        checkOutput("threeQueued", fifo_count, 3);
        checkOutput("ledsUnchanged", leds, 3'b000);
        drainFifo();

        // Caps toggle and a clean LED update
        sendByte(8'h58);
        checkOutput("capsOn", leds, 3'b100);
        serviceLeds(0, 0, 0, 0);
        checkOutput("only58", fifo_count, 1);
        checkOutput("head58", data_out, 8'h58);
        drainFifo();

        // Resend exhaustion on 0xED
        sendByte(8'h58);
        checkOutput("capsOff", leds, 3'b000);
        serviceLeds(4, 0, 0, 0);
        checkOutput("errAfterRetries", cmd_err, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("errCleared", cmd_err, 0);

        // Timeout after 0xED
        sendByte(8'h7E);
        serviceLeds(0, 0, 1, 0);
        checkOutput("errAfterTimeout", cmd_err, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checkState();
        drainFifo();

        // Pause sequence does not touch lock state
        foreach (pauseSeq[i]) sendByte(pauseSeq[i]);
        checkOutput("pauseLeds", leds, 3'b001);
        checkOutput("pauseQueued", fifo_count, 8);
        applyStimulus(1, 8'h77, 1, 0);
        checkState();
        checkOutput("numAfterPause", leds, 3'b011);
        serviceLeds(0, 0, 0, 0);
        drainFifo();

        // Overflow, push+pop on full, clear racing a new overflow
        for (int i = 0; i < DEPTH + 1; i++) sendByte(8'(8'h10 + i));
        checkOutput("fullCount", fifo_count, DEPTH);
        checkOutput("ovfSet", overflow, 1);
        applyStimulus(1, 8'h19, 1, 0);
        checkState();
        applyStimulus(1, 8'h1A, 0, 1);
        checkOutput("ovfSetWins", overflow, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("ovfCleared", overflow, 0);
        drainFifo();
        checkOutput("emptyData", data_out, 8'h00);

        // Reset in the middle of a sequence
        sendByte(8'h58);
        awaitTx(8'hED, got);
        rst = 1;
        tick();
        tick();
        rst = 0;
        modelReset();
        checkResetValues();
        repeat (10) begin
            tick();
            checkOutput("noTxAfterReset", tx_start, 0);
        end
        checkOutput("idleAfterReset", busy, 0);

        // Randomized traffic with keyboard answers chosen at random
        for (int it = 0; it < 250; it++) begin
            act = $urandom_range(0, 3);
            case (act)
                0:       applyStimulus(1, randPool(), 0, 0);
                1:       applyStimulus(0, 8'h00, 1, 0);
                2:       applyStimulus(1, randPool(), 1, 0);
                default: applyStimulus(0, 8'h00, 0, $urandom_range(0, 7) == 0);
            endcase
            checkState();
            if (mPending) begin
                serviceLeds($urandom_range(0, 4), $urandom_range(0, 4),
                            ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0,
                            $urandom_range(0, 1) == 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
